// File: rtl/iddmm_pkg.sv
// ----------------------------------------------------------------------------
// iddmm_pkg
// Shared types for the IDDMM task host.
//   host_state_t : host FSM states (IDLE, REQ, WAIT_GRANT, COLLECT, DRAIN)
//   err_code_t   : error code reported alongside the err pulse
// No ports; imported by iddmm_task_host.
// ----------------------------------------------------------------------------
package iddmm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_GRANT,
        COLLECT,
        DRAIN
    } host_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_SHORT   = 2'b01,
        ERR_OVF     = 2'b10,
        ERR_TIMEOUT = 2'b11
    } err_code_t;

endpackage

// File: rtl/iddmm_res_buf.sv
// ----------------------------------------------------------------------------
// iddmm_res_buf
// N x K simple dual-port result buffer: one write port, one read port with
// registered read data. Contents are not reset.
// Ports:
//   clk      : clock
//   wr_en    : write strobe, wr_data stored at wr_addr
//   wr_addr  : write word index
//   wr_data  : write word
//   rd_en    : read strobe, rd_data loads mem[rd_addr] on the next edge
//   rd_addr  : read word index
//   rd_data  : registered read word, holds while rd_en is low
// ----------------------------------------------------------------------------
module iddmm_res_buf #(
    parameter int K      = 128,
    parameter int N      = 32,
    parameter int ADDR_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [K-1:0]      wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [K-1:0]      rd_data
);

    logic [K-1:0] mem [N];

    // Storage array write port; plain RAM with no reset so it maps onto
    // block or distributed memory.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; the output register only updates on rd_en so the
    // host can hold a word steady while the downstream side stalls.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/iddmm_task_host.sv
// ----------------------------------------------------------------------------
// iddmm_task_host
// Requests one Montgomery task from the controller, collects N result words
// into a buffer, then streams them out over a valid/ready handshake.
// Optional macro: IDDMM_HOST_TIMEOUT_EN adds a grant-wait timeout (TIMEOUT).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : one-cycle task request (ignored while busy)
//   busy                : task in progress
//   done                : one-cycle pulse after the last word is drained
//   err, err_code       : one-cycle error pulse and its code
//   task_req            : one-cycle request to the controller
//   task_grant, task_end: controller word strobe and end-of-task flag
//   task_res            : controller result word
//   m_valid, m_ready    : downstream handshake
//   m_data, m_last, m_idx: downstream word, last flag and index
// ----------------------------------------------------------------------------
module iddmm_task_host
    import iddmm_pkg::*;
#(
    parameter int K       = 128,
    parameter int N       = 32,
    parameter int ADDR_W  = $clog2(N),
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic              task_req,
    input  logic              task_grant,
    input  logic              task_end,
    input  logic [K-1:0]      task_res,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [K-1:0]      m_data,
    output logic              m_last,
    output logic [ADDR_W-1:0] m_idx
);

    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(N);
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(N-1);

    host_state_t       state, state_nxt;
    logic [ADDR_W:0]   wr_cnt, wr_cnt_after, rd_cnt, rd_cnt_inc;
    logic              cap, ovf_err, short_err, tmo_err, tmo_hit;
    logic              first_rd, hs_adv, hs_last, rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [K-1:0]      rd_data;
    logic              m_valid_q, done_q, err_q;
    err_code_t         err_code_q;

`ifdef IDDMM_HOST_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT-1);

    logic [TMO_W-1:0] tmo_cnt;

    // Counts cycles since task_req; it already ticks during REQ so the
    // timeout lands TIMEOUT cycles after the request pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state == REQ || state == WAIT_GRANT) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign tmo_hit = (state == WAIT_GRANT) && !task_grant && (tmo_cnt == TMO_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    assign rd_cnt_inc = rd_cnt + 1'b1;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath control. WAIT_GRANT and COLLECT share the
    // capture logic: WAIT_GRANT only leaves on a grant (or timeout), and that
    // first grant is treated exactly like a COLLECT grant at wr_cnt=0, so a
    // task_end arriving with it is judged by the same short/complete rule.
    always_comb begin
        state_nxt    = state;
        cap          = 1'b0;
        ovf_err      = 1'b0;
        short_err    = 1'b0;
        tmo_err      = 1'b0;
        first_rd     = 1'b0;
        hs_adv       = 1'b0;
        hs_last      = 1'b0;
        rd_en        = 1'b0;
        wr_cnt_after = wr_cnt;
        rd_addr      = rd_cnt[ADDR_W-1:0];
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                state_nxt = WAIT_GRANT;
            end
            WAIT_GRANT, COLLECT: begin
                if (state == WAIT_GRANT && !task_grant) begin
                    if (tmo_hit) begin
                        tmo_err   = 1'b1;
                        state_nxt = IDLE;
                    end
                end else begin
                    cap          = task_grant && (wr_cnt < CNT_FULL);
                    ovf_err      = task_grant && (wr_cnt == CNT_FULL) && !task_end;
                    wr_cnt_after = wr_cnt + {{ADDR_W{1'b0}}, cap};
                    if (task_end) begin
                        if (wr_cnt_after == CNT_FULL) begin
                            state_nxt = DRAIN;
                        end else begin
                            short_err = 1'b1;
                            state_nxt = IDLE;
                        end
                    end else begin
                        state_nxt = COLLECT;
                    end
                end
            end
            DRAIN: begin
                if (!m_valid_q) begin
                    first_rd = 1'b1;
                    rd_en    = 1'b1;
                end else if (m_ready) begin
                    if (rd_cnt == CNT_LAST) begin
                        hs_last   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        hs_adv  = 1'b1;
                        rd_en   = 1'b1;
                        rd_addr = rd_cnt_inc[ADDR_W-1:0];
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Word counters. Both return to zero whenever the FSM heads back to
    // IDLE, which also discards a partially collected task.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            wr_cnt <= (state_nxt == IDLE) ? '0 : wr_cnt_after;
            if (hs_adv) begin
                rd_cnt <= rd_cnt_inc;
            end else if (state_nxt == IDLE) begin
                rd_cnt <= '0;
            end
        end
    end

    // Registered status outputs: m_valid rises the cycle the first read data
    // lands, done/err are single-cycle pulses following their cause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            if (first_rd) begin
                m_valid_q <= 1'b1;
            end else if (hs_last) begin
                m_valid_q <= 1'b0;
            end
            done_q <= hs_last;
            err_q  <= short_err | ovf_err | tmo_err;
            if (short_err) begin
                err_code_q <= ERR_SHORT;
            end else if (ovf_err) begin
                err_code_q <= ERR_OVF;
            end else if (tmo_err) begin
                err_code_q <= ERR_TIMEOUT;
            end else begin
                err_code_q <= ERR_NONE;
            end
        end
    end

    iddmm_res_buf #(
        .K      (K),
        .N      (N),
        .ADDR_W (ADDR_W)
    ) u_res_buf (
        .clk     (clk),
        .wr_en   (cap),
        .wr_addr (wr_cnt[ADDR_W-1:0]),
        .wr_data (task_res),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // The read register is not reset, so data and last flag are masked by
    // m_valid to keep the outputs at zero outside a drain.
    assign task_req = (state == REQ);
    assign busy     = (state != IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign err_code = err_code_q;
    assign m_valid  = m_valid_q;
    assign m_data   = m_valid_q ? rd_data : '0;
    assign m_last   = m_valid_q && (rd_cnt == CNT_LAST);
    assign m_idx    = rd_cnt[ADDR_W-1:0];

endmodule

// File: tb/tb_iddmm_task_host.sv
// ----------------------------------------------------------------------------
// tb_iddmm_task_host
// Self-checking bench for iddmm_task_host with K=128, N=4, TIMEOUT=16.
// Table-driven nominal task plus directed stall, short, overflow, reset and
// grant-wait sequences. Honours IDDMM_HOST_TIMEOUT_EN like the design.
// ----------------------------------------------------------------------------
module tb_iddmm_task_host;

    localparam int K   = 128;
    localparam int N   = 4;
    localparam int AW  = 2;
    localparam int TMO = 16;
    localparam int OW  = 4 + 2 + 2 + AW + K;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          task_grant = 1'b0;
    logic          task_end = 1'b0;
    logic [K-1:0]  task_res = '0;
    logic          m_ready = 1'b0;
    logic          busy, done, err, task_req, m_valid, m_last;
    logic [1:0]    err_code;
    logic [K-1:0]  m_data;
    logic [AW-1:0] m_idx;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    logic [1:0] last_err_code = 2'b00;
    logic [K-1:0] exp_words [N];

    typedef struct {
        logic          start;
        logic          grant;
        logic          tend;
        logic          ready;
        logic [K-1:0]  res;
        logic [OW-1:0] exp;
    } vec_t;

    vec_t vecs [13];

    iddmm_task_host #(
        .K       (K),
        .N       (N),
        .ADDR_W  (AW),
        .TIMEOUT (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .task_req   (task_req),
        .task_grant (task_grant),
        .task_end   (task_end),
        .task_res   (task_res),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_idx      (m_idx)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Error pulse monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (err) begin
            err_pulses    = err_pulses + 1;
            last_err_code = err_code;
        end
    end

    // Global watchdog so the bench can never hang.
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [OW-1:0] mk(input logic req, input logic bsy, input logic dn,
                                         input logic er, input logic [1:0] code,
                                         input logic mv, input logic ml,
                                         input logic [AW-1:0] idx, input logic [K-1:0] data);
        return {req, bsy, dn, er, code, mv, ml, idx, data};
    endfunction

    function automatic logic [OW-1:0] observed();
        return mk(task_req, busy, done, err, err_code, m_valid, m_last, m_idx, m_data);
    endfunction

    task automatic applyStimulus(input logic s, input logic g, input logic e,
                                 input logic rdy, input logic [K-1:0] d);
        start      = s;
        task_grant = g;
        task_end   = e;
        m_ready    = rdy;
        task_res   = d;
    endtask

    task automatic checkOutput(input string name, input logic [OW-1:0] act,
                               input logic [OW-1:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic startTask();
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, '0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
    endtask

    task automatic feedFull();
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            applyStimulus(1'b0, 1'b1, (i == N-1), 1'b1, exp_words[i]);
        end
    endtask

    // Drains with m_ready held high and compares every word, then done.
    task automatic drainCheck(input string tag);
        int idx;
        bit fin;
        idx = 0;
        fin = 1'b0;
        for (int k = 0; k < 20 && !fin; k++) begin
            @(negedge clk);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
            #1;
            if (m_valid) begin
                if (idx >= N) begin
                    checkOutput($sformatf("%s extra word", tag), OW'(idx), OW'(N-1));
                    fin = 1'b1;
                end else begin
                    checkOutput($sformatf("%s word %0d", tag, idx), observed(),
                                mk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, (idx == N-1),
                                   AW'(idx), exp_words[idx]));
                    if (m_last) fin = 1'b1;
                    idx = idx + 1;
                end
            end
        end
        if (fin) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("%s done", tag), observed(),
                        mk(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, '0, '0));
        end else begin
            checks = checks + 1;
            errors = errors + 1;
            $display("[TB] FAIL %s drain timeout: got %0d words, required %0d", tag, idx, N);
        end
    endtask

    initial begin
        logic rdy;
        int   idx;
        int   busy_low;
        bit   pv, pr, fin;
        logic [OW-1:0] pobs;

        // Nominal task, one row per cycle. Grant in REQ, start while busy and
        // grant/end during DRAIN are all expected to be ignored.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 128'h0,  mk(0,0,0,0,2'b00,0,0,2'd0,128'h0)};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 128'hEE, mk(1,1,0,0,2'b00,0,0,2'd0,128'h0)};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 128'h11, mk(0,1,0,0,2'b00,0,0,2'd0,128'h0)};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 128'h22, mk(0,1,0,0,2'b00,0,0,2'd0,128'h0)};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 128'h33, mk(0,1,0,0,2'b00,0,0,2'd0,128'h0)};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 128'h44, mk(0,1,0,0,2'b00,0,0,2'd0,128'h0)};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 128'h0,  mk(0,1,0,0,2'b00,0,0,2'd0,128'h0)};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 128'h99, mk(0,1,0,0,2'b00,1,0,2'd0,128'h11)};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 128'h0,  mk(0,1,0,0,2'b00,1,0,2'd1,128'h22)};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 128'h0,  mk(0,1,0,0,2'b00,1,0,2'd2,128'h33)};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 128'h0,  mk(0,1,0,0,2'b00,1,1,2'd3,128'h44)};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 128'h0,  mk(0,0,1,0,2'b00,0,0,2'd0,128'h0)};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 128'h0,  mk(0,0,0,0,2'b00,0,0,2'd0,128'h0)};

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset outputs", observed(), '0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].start, vecs[i].grant, vecs[i].tend, vecs[i].ready, vecs[i].res);
            #1;
            checkOutput($sformatf("nominal row %0d", i), observed(), vecs[i].exp);
        end

        // Backpressure with m_ready pattern 1,0,0 repeating.
        exp_words[0] = 128'h11; exp_words[1] = 128'h22;
        exp_words[2] = 128'h33; exp_words[3] = 128'h44;
        startTask();
        feedFull();
        idx = 0; pv = 1'b0; pr = 1'b0; fin = 1'b0; pobs = '0;
        for (int k = 0; k < 40 && !fin; k++) begin
            rdy = ((k % 3) == 0);
            @(negedge clk);
            applyStimulus(1'b0, 1'b0, 1'b0, rdy, '0);
            #1;
            if (m_valid) begin
                if (pv && !pr) checkOutput($sformatf("stall hold k=%0d", k), observed(), pobs);
                if (rdy) begin
                    if (idx >= N) begin
                        checkOutput("stall extra word", OW'(idx), OW'(N-1));
                        fin = 1'b1;
                    end else begin
                        checkOutput($sformatf("stall word %0d", idx), observed(),
                                    mk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, (idx == N-1),
                                       AW'(idx), exp_words[idx]));
                        if (m_last) fin = 1'b1;
                        idx = idx + 1;
                    end
                end
            end
            pv = m_valid; pr = rdy; pobs = observed();
        end
        checkOutput("stall word count", OW'(idx), OW'(N));
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
        #1;
        checkOutput("stall done", observed(), mk(0,0,1,0,2'b00,0,0,2'd0,128'h0));

        // Short task: task_end with the second word.
        startTask();
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 128'hA1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 128'hA2);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, '0);
        #1;
        checkOutput("short err", observed(), mk(0,0,0,1,2'b01,0,0,2'd0,128'h0));
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
        #1;
        checkOutput("restart after short", observed(), mk(1,1,0,0,2'b00,0,0,2'd0,128'h0));
        exp_words[0] = 128'hB1; exp_words[1] = 128'hB2;
        exp_words[2] = 128'hB3; exp_words[3] = 128'hB4;
        feedFull();
        drainCheck("after short");

        // Overflow: five grants, task_end on the following cycle.
        exp_words[0] = 128'h01; exp_words[1] = 128'h02;
        exp_words[2] = 128'h03; exp_words[3] = 128'h04;
        err_pulses = 0;
        startTask();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, (i < N) ? exp_words[i] : 128'h05);
        end
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, '0);
        #1;
        checkOutput("ovf err", observed(), mk(0,1,0,1,2'b10,0,0,2'd0,128'h0));
        drainCheck("ovf");
        checkOutput("ovf err pulse count", OW'(err_pulses), OW'(1));

        // Reset in the middle of collection.
        startTask();
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 128'hC1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 128'hC2);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
        #1;
        checkOutput("pre-reset busy", observed(), mk(0,1,0,0,2'b00,0,0,2'd0,128'h0));
        #1 rst_n = 1'b0;
        #1;
        checkOutput("mid-task reset outputs", observed(), '0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_words[0] = 128'hD1; exp_words[1] = 128'hD2;
        exp_words[2] = 128'hD3; exp_words[3] = 128'hD4;
        startTask();
        feedFull();
        drainCheck("after reset");

        // Grant never arrives.
`ifdef IDDMM_HOST_TIMEOUT_EN
        startTask();
        fin = 1'b0;
        for (int k = 1; k <= 40 && !fin; k++) begin
            @(negedge clk);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
            #1;
            if (err) begin
                checkOutput("timeout latency", OW'(k), OW'(TMO));
                checkOutput("timeout err", observed(), mk(0,0,0,1,2'b11,0,0,2'd0,128'h0));
                fin = 1'b1;
            end
        end
        if (!fin) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("[TB] FAIL timeout: got no err within 40 cycles, required err after %0d", TMO);
        end
`else
        err_pulses = 0;
        busy_low = 0;
        startTask();
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
            #1;
            if (!busy) busy_low = busy_low + 1;
        end
        checkOutput("no-timeout busy low cycles", OW'(busy_low), '0);
        checkOutput("no-timeout err pulses", OW'(err_pulses), '0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`endif

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
